// File: rtl/fadd_arbiter.sv
// Round-robin front end that shares one pipelined fadd_multi unit among NUM_REQ requesters.
// Optional feature macro: FADD_ARB_SUB_EN (issue x1-x2 by flipping the sign of x2 when req_sub is set).
module fadd_arbiter #(
  parameter  int NUM_REQ  = 2,
  parameter  int FADD_LAT = 2,
  parameter  int MAX_OUT  = 2,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_x1,
  input  logic [NUM_REQ*32-1:0] req_x2,
  input  logic [NUM_REQ-1:0]    req_sub,
  output logic [31:0]           fadd_x1,
  output logic [31:0]           fadd_x2,
  input  logic [31:0]           fadd_y,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [31:0]           rsp_y,
  output logic                  busy
);

  localparam int CW = $clog2(MAX_OUT + 1);

  logic [IDW-1:0]                ptr_q, ptr_d;
  logic [NUM_REQ-1:0][CW-1:0]    cnt_q, cnt_d;
  logic [31:0]                   fadd_x1_q, fadd_x1_d;
  logic [31:0]                   fadd_x2_q, fadd_x2_d;
  logic [FADD_LAT:0]             pv_q, pv_d;
  logic [FADD_LAT:0][IDW-1:0]    pid_q, pid_d;

  logic [NUM_REQ-1:0]            elig_s;
  logic [NUM_REQ-1:0]            grant_s;
  logic                          found_s;
  logic [IDW-1:0]                gnt_id_s;
  logic [31:0]                   sel_x1_s;
  logic [31:0]                   sel_x2_s;

`ifndef FADD_ARB_SUB_EN
  logic sub_unused;
  assign sub_unused = ^req_sub;
`endif

  // Eligibility and round-robin grant search starting at ptr.
  always_comb begin
    int idx;
    elig_s   = '0;
    grant_s  = '0;
    found_s  = 1'b0;
    gnt_id_s = '0;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig_s[i] = req_valid[i] & (cnt_q[i] < CW'(MAX_OUT));
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (!found_s && elig_s[idx]) begin
        found_s  = 1'b1;
        gnt_id_s = IDW'(idx);
      end else begin
        found_s  = found_s;
      end
    end
    if (found_s) begin
      grant_s[gnt_id_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // Operand mux for the granted requester, with optional sign flip on x2.
  always_comb begin
    sel_x1_s = req_x1[32*int'(gnt_id_s) +: 32];
    sel_x2_s = req_x2[32*int'(gnt_id_s) +: 32];
`ifdef FADD_ARB_SUB_EN
    sel_x2_s = {sel_x2_s[31] ^ req_sub[gnt_id_s], sel_x2_s[30:0]};
`endif
  end

  // Next state: pointer, issue register, id pipe and per-requester in-flight counts.
  always_comb begin
    ptr_d     = ptr_q;
    fadd_x1_d = 32'd0;
    fadd_x2_d = 32'd0;
    pv_d      = '0;
    pid_d     = '0;
    cnt_d     = cnt_q;
    if (found_s) begin
      ptr_d     = (gnt_id_s == IDW'(NUM_REQ - 1)) ? '0 : gnt_id_s + IDW'(1);
      fadd_x1_d = sel_x1_s;
      fadd_x2_d = sel_x2_s;
    end else begin
      ptr_d     = ptr_q;
    end
    pv_d[0]  = found_s;
    pid_d[0] = gnt_id_s;
    for (int s = 1; s <= FADD_LAT; s++) begin
      pv_d[s]  = pv_q[s-1];
      pid_d[s] = pid_q[s-1];
    end
    // Counter uses the registered response, so a returning op frees its slot one cycle later.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i] && !(pv_q[FADD_LAT] && (pid_q[FADD_LAT] == IDW'(i)))) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (!grant_s[i] && pv_q[FADD_LAT] && (pid_q[FADD_LAT] == IDW'(i))) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      cnt_q     <= '0;
      fadd_x1_q <= 32'd0;
      fadd_x2_q <= 32'd0;
      pv_q      <= '0;
      pid_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      fadd_x1_q <= fadd_x1_d;
      fadd_x2_q <= fadd_x2_d;
      pv_q      <= pv_d;
      pid_q     <= pid_d;
    end
  end

  assign req_ready = grant_s;
  assign fadd_x1   = fadd_x1_q;
  assign fadd_x2   = fadd_x2_q;
  assign rsp_valid = pv_q[FADD_LAT];
  assign rsp_id    = pid_q[FADD_LAT];
  assign rsp_y     = fadd_y;
  assign busy      = |pv_q;

endmodule

// File: tb/tb_fadd_arbiter.sv
// Scoreboard bench for fadd_arbiter (NUM_REQ=3, FADD_LAT=2, MAX_OUT=2) with a stand-in 2-stage adder.
module tb_fadd_arbiter;
  localparam int NR = 3;

`ifdef FADD_ARB_SUB_EN
  localparam logic [31:0] SUB_EXP = 32'h40000000;
`else
  localparam logic [31:0] SUB_EXP = 32'h40800000;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NR-1:0]  req_valid = '0;
  logic [NR-1:0]  req_ready;
  logic [NR*32-1:0] req_x1 = '0;
  logic [NR*32-1:0] req_x2 = '0;
  logic [NR-1:0]  req_sub = '0;
  logic [31:0]    fadd_x1, fadd_x2, fadd_y, rsp_y;
  logic           rsp_valid, busy;
  logic [1:0]     rsp_id;
  logic [31:0]    fy1 = 32'd0, fy2 = 32'd0;

  typedef struct { int id; logic [31:0] y; int cyc; } exp_t;
  exp_t        sb[$];
  logic [31:0] exp_y [NR];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  fadd_arbiter #(.NUM_REQ(NR), .FADD_LAT(2), .MAX_OUT(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x1(req_x1), .req_x2(req_x2), .req_sub(req_sub),
    .fadd_x1(fadd_x1), .fadd_x2(fadd_x2), .fadd_y(fadd_y),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in adder: known IEEE sums for the directed vectors, XOR for the streaming patterns.
  function automatic logic [31:0] fadd_ref(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3F800000_40000000: fadd_ref = 32'h40400000;
      64'h40400000_3F800000: fadd_ref = 32'h40800000;
      64'h40400000_BF800000: fadd_ref = 32'h40000000;
      default:               fadd_ref = a ^ b;
    endcase
  endfunction

  always @(posedge clk) begin
    fy1 <= fadd_ref(fadd_x1, fadd_x2);
    fy2 <= fy1;
  end
  assign fadd_y = fy2;

  // Record accepted ops with the expected response and the cycle it is due.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) sb.push_back('{id: i, y: exp_y[i], cyc: cyc + 3});
      end
    end
    cyc = cyc + 1;
  end

  // Monitor: every response must match the oldest outstanding op.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp got id=%0d y=%h at cyc %0d, required none", rsp_id, rsp_y, cyc);
      end else begin
        e = sb.pop_front();
        if (int'(rsp_id) != e.id || rsp_y !== e.y || cyc != e.cyc)
          begin
            errors++;
            $display("FAIL rsp got id=%0d y=%h cyc=%0d, required id=%0d y=%h cyc=%0d",
                     rsp_id, rsp_y, cyc, e.id, e.y, e.cyc);
          end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] y);
    req_x1[32*i +: 32] = a;
    req_x2[32*i +: 32] = b;
    req_sub[i]         = s;
    exp_y[i]           = y;
  endtask

  // Drive valids for one cycle and check the grant; called and returns at posedge+1.
  task automatic cycle_chk(input logic [NR-1:0] v, input logic [NR-1:0] rdy, input string name);
    req_valid = v;
    @(negedge clk);
    chk(name, 32'(req_ready), 32'(rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cycle_chk(3'b000, 3'b000, "idle_ready");
  endtask

  initial begin
    logic [31:0] a, b;
    int wait_cnt;
    for (int i = 0; i < NR; i++) exp_y[i] = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_fadd_x1", fadd_x1, 32'd0);
    chk("reset_fadd_x2", fadd_x2, 32'd0);
    @(posedge clk);
    #1;

    // 1.0 + 2.0 from requester 0.
    set_op(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
    cycle_chk(3'b001, 3'b001, "t1_ready");
    req_valid = '0;
    @(negedge clk);
    chk("t1_issue_x1", fadd_x1, 32'h3F800000);
    chk("t1_issue_x2", fadd_x2, 32'h40000000);
    chk("t1_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    idle(5);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_fadd_x1", fadd_x1, 32'd0);
    @(posedge clk);
    #1;

    // 3.0 with req_sub set (ptr now 1, requester 0 still found by wrap).
    set_op(0, 32'h40400000, 32'h3F800000, 1'b1, SUB_EXP);
    cycle_chk(3'b001, 3'b001, "sub_ready");
    req_sub = '0;
    idle(5);

    // Wrap: grant 1 moves ptr to 2, then 2 beats 0, then 0, then ptr=1 picks 1.
    set_op(1, 32'h11110000, 32'h00002222, 1'b0, 32'h11112222);
    cycle_chk(3'b010, 3'b010, "wrap_pre1");
    set_op(0, 32'h0F0F0000, 32'h000000F0, 1'b0, 32'h0F0F00F0);
    set_op(2, 32'h22220000, 32'h00004444, 1'b0, 32'h22224444);
    cycle_chk(3'b101, 3'b100, "wrap_grant2");
    cycle_chk(3'b101, 3'b001, "wrap_grant0");
    set_op(1, 32'h33330000, 32'h00005555, 1'b0, 32'h33335555);
    cycle_chk(3'b111, 3'b010, "wrap_ptr1");
    idle(5);

    // Two requesters streaming: alternating grants at full rate (ptr=2 -> 0 first).
    for (int k = 0; k < 8; k++) begin
      a = 32'hA0000000 | 32'(k);
      b = 32'h00050000 + (32'(k) << 8);
      set_op(0, a, b, 1'b0, a ^ b);
      set_op(1, b, 32'h0C000000, 1'b0, b ^ 32'h0C000000);
      cycle_chk(3'b011, (k % 2 == 0) ? 3'b001 : 3'b010, "alt_grant");
    end
    idle(5);

    // One requester held valid: MAX_OUT=2 throttles to 2 accepts per 4 cycles.
    for (int k = 0; k < 8; k++) begin
      a = 32'h5A000000 + 32'(k);
      set_op(0, a, 32'h00A50000, 1'b0, a ^ 32'h00A50000);
      cycle_chk(3'b001, (k % 4 < 2) ? 3'b001 : 3'b000, "throttle_ready");
    end
    idle(5);

    // Reset with two ops in flight: nothing stale comes back, state is cleared.
    set_op(0, 32'h12340000, 32'h00005678, 1'b0, 32'h12345678);
    set_op(1, 32'h0BAD0000, 32'h0000F00D, 1'b0, 32'h0BADF00D);
    cycle_chk(3'b011, 3'b010, "rst_pre_grant1");
    cycle_chk(3'b011, 3'b001, "rst_pre_grant0");
    rst = 1'b1;
    req_valid = '0;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid = 3'b111;
    @(negedge clk);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_ptr_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = '0;
    idle(6);
    set_op(0, 32'h7E000000, 32'h00000081, 1'b0, 32'h7E000081);
    cycle_chk(3'b001, 3'b001, "post_rst_cnt_a");
    cycle_chk(3'b001, 3'b001, "post_rst_cnt_b");
    cycle_chk(3'b001, 3'b000, "post_rst_cnt_full");
    req_valid = '0;

    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d outstanding required 0", sb.size());
    end
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
